// File: rtl/bcd_serial_addsub_pkg.sv
// Shared encodings and helpers for the digit-serial BCD adder/subtractor.
package bcd_serial_addsub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    function automatic logic digit_bad(input logic [3:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit of add or subtract (9's complement of b when sub), with +6 decimal correction.
module bcd_digit_add
    import bcd_serial_addsub_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] digit,
    output logic       cout
);

    logic [3:0] bb;
    logic [4:0] t;

    always_comb begin
        bb    = sub ? (BCD_MAX - b) : b;
        t     = {1'b0, a} + {1'b0, bb} + {4'b0000, cin};
        digit = t[3:0];
        cout  = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            digit = t[3:0] + BCD_CORR;
            cout  = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LS digit first.
module bcd_serial_addsub
    import bcd_serial_addsub_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  c_out,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake: start is accepted only in IDLE (one edge); done pulses one
    // cycle when sum/c_out/err are valid; start outside IDLE is dropped.
    logic [1:0]    state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub_q;
    logic          carry;
    logic [IW-1:0] idx;
    logic          in_bad;
    logic [3:0]    digit;
    logic          dcout;

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_bad(a[4*i +: 4]) || digit_bad(b[4*i +: 4]))
                in_bad = 1'b1;
        end
    end

    // Operands shift right so the digit in flight is always at [3:0].
    bcd_digit_add u_digit (
        .a     (a_q[3:0]),
        .b     (b_q[3:0]),
        .cin   (carry),
        .sub   (sub_q),
        .digit (digit),
        .cout  (dcout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= op_sub;
                        carry <= op_sub;
                        idx   <= '0;
                        sum   <= '0;
                        c_out <= 1'b0;
                        if (in_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i))
                            sum[4*i +: 4] <= digit;
                    end
                    carry <= dcout;
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    idx   <= idx + 1'b1;
                    if (idx == IW'(DIGITS - 1)) begin
                        c_out <= dcout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
